filt_seq_ctrl: RTL and testbench
================================

# filt_seq_ctrl

Tap sequencer and handshake controller for the FIR filter datapath between the I2S input and I2S output blocks. It accepts one sample per rts/rtr handshake and writes it into the filter's sample-history ring. It then steps the MAC through every tap, one per cycle, waits out the MAC pipeline, and loads the result. Finally it offers that result downstream with an rts/rtr handshake. It also zero-fills the history after reset and on request.

## Interface
Parameters:
- NTAPS, 16, number of filter taps; power of 2, at least 2
- MAC_LAT, 2, MAC pipeline latency in cycles from the last mac_en to a valid accumulator; at least 1
- AW, $clog2(NTAPS), history and coefficient index width (derived)

Ports:
- clk  in  1  master clock
- rst  in  1  reset; synchronous, active-high
- rf_filter_en  in  1  enables sample acceptance
- rf_hist_clr  in  1  single-cycle pulse requesting a history zero-fill
- aud_in_rts  in  1  upstream sample available
- aud_in_rtr  out  1  ready to accept an upstream sample
- aud_out_rts  out  1  filtered sample available downstream
- aud_out_rtr  in  1  downstream ready
- hist_wr_en  out  1  history write strobe
- hist_wr_zero  out  1  write zero instead of the input sample
- hist_wr_ptr  out  AW  history write address
- hist_rd_ptr  out  AW  history read address for the current tap
- coef_idx  out  AW  coefficient index for the current tap
- mac_en  out  1  MAC accumulate strobe
- mac_clr  out  1  clear accumulator before accumulating (first tap)
- mac_last  out  1  final tap of the sample
- out_load  out  1  datapath latches the accumulator into its output register

## Operation
- States:
  - CLR: zero-fill sweep, one address per cycle.
  - IDLE: ready for a new sample.
  - MAC: one tap per cycle.
  - WAIT: covers the MAC pipeline latency.
  - LOAD: output register load.
  - OUT: result offered downstream.
- Reset: state goes to CLR. wptr, tap counter and wait counter go to 0. All outputs are 0 except as CLR drives them.
- CLR:
  - Drives hist_wr_en=1, hist_wr_zero=1 and hist_wr_ptr=0..NTAPS-1 over NTAPS cycles.
  - Then sets wptr=0 and goes to IDLE.
  - aud_in_rtr=0 throughout.
- IDLE:
  - aud_in_rtr = rf_filter_en.
  - hist_wr_en = aud_in_rts && aud_in_rtr (combinational), with hist_wr_ptr=wptr.
  - On that handshake: newest<=wptr, wptr<=wptr+1 (mod NTAPS), go to MAC.
  - An rf_hist_clr pulse with no handshake in the same cycle sends IDLE to CLR.
- MAC: for k=0..NTAPS-1 on consecutive cycles:
  - mac_en=1, coef_idx=k, hist_rd_ptr=(newest−k) mod NTAPS, computed in AW bits with natural wrap.
  - mac_clr=1 only at k=0; mac_last=1 only at k=NTAPS-1.
- WAIT: MAC_LAT cycles with all strobes 0.
- LOAD: out_load=1 for exactly one cycle, then go to OUT.
- OUT:
  - aud_out_rts=1 until aud_out_rtr=1 is sampled, then go to IDLE on the next cycle.
  - aud_in_rtr=0.
- rf_filter_en deasserted outside IDLE: the current sample completes normally. Only new acceptance is blocked.
- rf_hist_clr pulses outside IDLE are ignored and not queued.
- rf_hist_clr and a handshake in the same IDLE cycle: the handshake wins and the clear is dropped.
- rst mid-operation: abort immediately and restart at CLR. A pending output is discarded and aud_out_rts drops on the cycle after rst.

## Timing
- Accept at cycle N:
  - MAC runs N+1 .. N+NTAPS.
  - WAIT runs N+NTAPS+1 .. N+NTAPS+MAC_LAT.
  - out_load occurs at N+NTAPS+MAC_LAT+1.
  - aud_out_rts first rises at N+NTAPS+MAC_LAT+2.
- Throughput: at most one sample per NTAPS+MAC_LAT+3 cycles when downstream is always ready. The earliest next accept is the cycle after the OUT handshake.
- Output registering:
  - All outputs are registered except aud_in_rtr, hist_wr_en, hist_wr_ptr and hist_wr_zero.
  - In IDLE those four are combinational from state, wptr and aud_in_rts.
- After rst deasserts, CLR occupies NTAPS cycles; aud_in_rtr first rises NTAPS+1 cycles after rst falls.

## Configuration
- FILT_SEQ_CTRL_BYPASS_EN defined:
  - Adds input rf_filter_bypass and output out_sel (1 bit each).
  - rf_filter_bypass is sampled at the accept cycle. If it is 1, the history write still happens, MAC and WAIT are skipped, and the next state is LOAD with out_sel=1.
  - Bypass latency: out_load at N+1, aud_out_rts at N+2.
  - out_sel is 0 on every filtered load.
- Not defined: neither port exists and every sample takes the filtered path.

## Structure
- Package filt_seq_ctrl_pkg holds:
  - the state enumeration (CLR, IDLE, MAC, WAIT, LOAD, OUT) and its 3-bit encoding;
  - the NTAPS and MAC_LAT defaults.
- One sub-module, filt_seq_ring_ptr: the AW-bit write pointer with increment and clear, plus the modular (newest−k) read-address computation.
- The state machine and the tap and wait counters stay in the top module.

## Test plan
All scenarios use NTAPS=4 and MAC_LAT=2.
- Reset then idle: hist_wr_en=1 with hist_wr_zero=1 at ptr 0,1,2,3 on 4 consecutive cycles. aud_in_rtr rises on the 5th cycle after rst falls.
- Single sample, accept at cycle N:
  - hist_rd_ptr sequence is 0,3,2,1 at N+1..N+4, with mac_clr at N+1 and mac_last at N+4.
  - out_load at N+7; aud_out_rts at N+8.
- Five back-to-back samples with aud_out_rtr=1: hist_wr_ptr takes 0,1,2,3,0 (wrap). The fifth sample's rd_ptr sequence is 0,3,2,1.
- Downstream stall: aud_out_rtr held 0 for 10 cycles. aud_out_rts stays 1 and aud_in_rtr stays 0, and aud_in_rts=1 is not accepted. Release aud_out_rtr: IDLE is reached the next cycle.
- Simultaneous rf_hist_clr and handshake in IDLE: the sample is accepted and no CLR sweep follows. An rf_hist_clr pulse in a later IDLE cycle gives a 4-cycle sweep.
- rst asserted during MAC at tap 2: all strobes are 0 on the next cycle and the CLR sweep restarts. With FILT_SEQ_CTRL_BYPASS_EN, rf_filter_bypass=1 gives out_load with out_sel=1 at N+1.

Source files
------------

// File: rtl/filt_seq_ctrl_pkg.sv
// Shared types and defaults for the FIR tap sequencer.
package filt_seq_ctrl_pkg;

    localparam int unsigned NTAPS_DEF   = 16;
    localparam int unsigned MAC_LAT_DEF = 2;

    typedef enum logic [2:0] {
        ST_CLR  = 3'd0,
        ST_IDLE = 3'd1,
        ST_MAC  = 3'd2,
        ST_WAIT = 3'd3,
        ST_LOAD = 3'd4,
        ST_OUT  = 3'd5
    } state_e;

endpackage

// File: rtl/filt_seq_ring_ptr.sv
// History ring write pointer plus the (base - k) tap read-address computation.
module filt_seq_ring_ptr
    import filt_seq_ctrl_pkg::*;
#(
    parameter int unsigned AW = $clog2(NTAPS_DEF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_inc,
    input  logic [AW-1:0] i_base,
    input  logic [AW-1:0] i_k,
    output logic [AW-1:0] o_wptr,
    output logic [AW-1:0] o_rd_ptr_c
);

    logic [AW-1:0] r_wptr;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_wptr <= '0;
        end else if (i_inc) begin
            r_wptr <= r_wptr + AW'(1);
        end
    end

    assign o_wptr     = r_wptr;
    // Natural AW-bit wrap gives the modular distance back from the newest sample.
    assign o_rd_ptr_c = i_base - i_k;

endmodule

// File: rtl/filt_seq_ctrl.sv
// FIR tap sequencer: history write, MAC tap stepping, pipeline wait, output handshake.
// Optional FILT_SEQ_CTRL_BYPASS_EN adds rf_filter_bypass/out_sel for an unfiltered path.
module filt_seq_ctrl
    import filt_seq_ctrl_pkg::*;
#(
    parameter int unsigned NTAPS   = NTAPS_DEF,
    parameter int unsigned MAC_LAT = MAC_LAT_DEF,
    parameter int unsigned AW      = $clog2(NTAPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rf_filter_en,
    input  logic          rf_hist_clr,
    input  logic          aud_in_rts,
    output logic          aud_in_rtr,
    output logic          aud_out_rts,
    input  logic          aud_out_rtr,
    output logic          hist_wr_en,
    output logic          hist_wr_zero,
    output logic [AW-1:0] hist_wr_ptr,
    output logic [AW-1:0] hist_rd_ptr,
    output logic [AW-1:0] coef_idx,
    output logic          mac_en,
    output logic          mac_clr,
    output logic          mac_last,
`ifdef FILT_SEQ_CTRL_BYPASS_EN
    input  logic          rf_filter_bypass,
    output logic          out_sel,
`endif
    output logic          out_load
);

    localparam int unsigned   WW        = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [AW-1:0] LAST_TAP  = AW'(NTAPS - 1);
    localparam logic [WW-1:0] LAST_WAIT = WW'(MAC_LAT - 1);

    state_e        r_state, w_nxt_state;
    logic [AW-1:0] r_tap, w_nxt_tap;
    logic [WW-1:0] r_wait, w_nxt_wait;
    logic [AW-1:0] r_newest;
    logic [AW-1:0] w_wptr, w_rd_base, w_rd_ptr;
    logic          w_accept, w_sweep_done;
    logic          r_mac_en, r_mac_clr, r_mac_last, r_out_load, r_aud_out_rts;
    logic          w_nxt_mac_en, w_nxt_mac_clr, w_nxt_mac_last, w_nxt_out_load, w_nxt_rts;
    logic [AW-1:0] r_hist_rd_ptr, r_coef_idx;
`ifdef FILT_SEQ_CTRL_BYPASS_EN
    logic          r_out_sel, w_nxt_out_sel;
`endif

    // Base is the write pointer on the accept cycle, then the captured newest slot.
    assign w_rd_base = (r_state == ST_IDLE) ? w_wptr : r_newest;

    filt_seq_ring_ptr #(
        .AW(AW)
    ) u_ring_ptr (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_sweep_done),
        .i_inc     (w_accept),
        .i_base    (w_rd_base),
        .i_k       (w_nxt_tap),
        .o_wptr    (w_wptr),
        .o_rd_ptr_c(w_rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_CLR;
            r_tap         <= '0;
            r_wait        <= '0;
            r_newest      <= '0;
            r_mac_en      <= 1'b0;
            r_mac_clr     <= 1'b0;
            r_mac_last    <= 1'b0;
            r_out_load    <= 1'b0;
            r_aud_out_rts <= 1'b0;
            r_hist_rd_ptr <= '0;
            r_coef_idx    <= '0;
`ifdef FILT_SEQ_CTRL_BYPASS_EN
            r_out_sel     <= 1'b0;
`endif
        end else begin
            r_state       <= w_nxt_state;
            r_tap         <= w_nxt_tap;
            r_wait        <= w_nxt_wait;
            r_newest      <= w_accept ? w_wptr : r_newest;
            r_mac_en      <= w_nxt_mac_en;
            r_mac_clr     <= w_nxt_mac_clr;
            r_mac_last    <= w_nxt_mac_last;
            r_out_load    <= w_nxt_out_load;
            r_aud_out_rts <= w_nxt_rts;
            r_hist_rd_ptr <= w_nxt_mac_en ? w_rd_ptr : '0;
            r_coef_idx    <= w_nxt_mac_en ? w_nxt_tap : '0;
`ifdef FILT_SEQ_CTRL_BYPASS_EN
            r_out_sel     <= w_nxt_out_sel;
`endif
        end
    end

    // Registered strobes are computed for the state being entered.
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_tap      = '0;
        w_nxt_wait     = '0;
        w_nxt_mac_en   = 1'b0;
        w_nxt_mac_clr  = 1'b0;
        w_nxt_mac_last = 1'b0;
        w_nxt_out_load = 1'b0;
        w_nxt_rts      = 1'b0;
        w_accept       = 1'b0;
        w_sweep_done   = 1'b0;
        aud_in_rtr     = 1'b0;
        hist_wr_en     = 1'b0;
        hist_wr_zero   = 1'b0;
        hist_wr_ptr    = w_wptr;
`ifdef FILT_SEQ_CTRL_BYPASS_EN
        w_nxt_out_sel  = r_out_sel;
`endif
        case (r_state)
            ST_CLR: begin
                hist_wr_en   = 1'b1;
                hist_wr_zero = 1'b1;
                hist_wr_ptr  = r_tap;
                if (r_tap == LAST_TAP) begin
                    w_sweep_done = 1'b1;
                    w_nxt_state  = ST_IDLE;
                end else begin
                    w_nxt_tap = r_tap + AW'(1);
                end
            end
            ST_IDLE: begin
                aud_in_rtr = rf_filter_en;
                w_accept   = aud_in_rts && rf_filter_en;
                hist_wr_en = w_accept;
                if (w_accept) begin
                    w_nxt_state   = ST_MAC;
                    w_nxt_mac_en  = 1'b1;
                    w_nxt_mac_clr = 1'b1;
`ifdef FILT_SEQ_CTRL_BYPASS_EN
                    w_nxt_out_sel = 1'b0;
                    if (rf_filter_bypass) begin
                        w_nxt_state    = ST_LOAD;
                        w_nxt_mac_en   = 1'b0;
                        w_nxt_mac_clr  = 1'b0;
                        w_nxt_out_load = 1'b1;
                        w_nxt_out_sel  = 1'b1;
                    end
`endif
                end else if (rf_hist_clr) begin
                    w_nxt_state = ST_CLR;
                end
            end
            ST_MAC: begin
                if (r_tap == LAST_TAP) begin
                    w_nxt_state = ST_WAIT;
                end else begin
                    w_nxt_tap      = r_tap + AW'(1);
                    w_nxt_mac_en   = 1'b1;
                    w_nxt_mac_last = (w_nxt_tap == LAST_TAP);
                end
            end
            ST_WAIT: begin
                if (r_wait == LAST_WAIT) begin
                    w_nxt_state    = ST_LOAD;
                    w_nxt_out_load = 1'b1;
                end else begin
                    w_nxt_wait = r_wait + WW'(1);
                end
            end
            ST_LOAD: begin
                w_nxt_state = ST_OUT;
                w_nxt_rts   = 1'b1;
            end
            ST_OUT: begin
                if (aud_out_rtr) begin
                    w_nxt_state = ST_IDLE;
                end else begin
                    w_nxt_rts = 1'b1;
                end
            end
            default: begin
                w_nxt_state = ST_CLR;
            end
        endcase
    end

    assign aud_out_rts = r_aud_out_rts;
    assign hist_rd_ptr = r_hist_rd_ptr;
    assign coef_idx    = r_coef_idx;
    assign mac_en      = r_mac_en;
    assign mac_clr     = r_mac_clr;
    assign mac_last    = r_mac_last;
    assign out_load    = r_out_load;
`ifdef FILT_SEQ_CTRL_BYPASS_EN
    assign out_sel     = r_out_sel;
`endif

endmodule

// File: tb/tb_filt_seq_ctrl.sv
// Scoreboard bench for filt_seq_ctrl with NTAPS=4, MAC_LAT=2.
module tb_filt_seq_ctrl;

    localparam int NT  = 4;
    localparam int ML  = 2;
    localparam int AWT = 2;

    typedef struct packed {
        logic [AWT-1:0] rd;
        logic [AWT-1:0] coef;
        logic           clr;
        logic           last;
    } mac_t;

    logic           clk, rst, rf_filter_en, rf_hist_clr;
    logic           aud_in_rts, aud_in_rtr, aud_out_rts, aud_out_rtr;
    logic           hist_wr_en, hist_wr_zero, mac_en, mac_clr, mac_last, out_load;
    logic [AWT-1:0] hist_wr_ptr, hist_rd_ptr, coef_idx;
`ifdef FILT_SEQ_CTRL_BYPASS_EN
    logic           rf_filter_bypass, out_sel;
`endif

    int   n_tests;
    int   n_fail;
    int   m_wptr;
    mac_t exp_q[$];
    mac_t obs_q[$];

    filt_seq_ctrl #(
        .NTAPS  (NT),
        .MAC_LAT(ML)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rf_filter_en    (rf_filter_en),
        .rf_hist_clr     (rf_hist_clr),
        .aud_in_rts      (aud_in_rts),
        .aud_in_rtr      (aud_in_rtr),
        .aud_out_rts     (aud_out_rts),
        .aud_out_rtr     (aud_out_rtr),
        .hist_wr_en      (hist_wr_en),
        .hist_wr_zero    (hist_wr_zero),
        .hist_wr_ptr     (hist_wr_ptr),
        .hist_rd_ptr     (hist_rd_ptr),
        .coef_idx        (coef_idx),
        .mac_en          (mac_en),
        .mac_clr         (mac_clr),
        .mac_last        (mac_last),
`ifdef FILT_SEQ_CTRL_BYPASS_EN
        .rf_filter_bypass(rf_filter_bypass),
        .out_sel         (out_sel),
`endif
        .out_load        (out_load)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_expected(input int newest);
        mac_t e;
        for (int k = 0; k < NT; k++) begin
            e.rd   = AWT'((newest - k + NT) % NT);
            e.coef = AWT'(k);
            e.clr  = (k == 0);
            e.last = (k == NT - 1);
            exp_q.push_back(e);
        end
    endtask

    // Offers one sample, records what the DUT does until aud_out_rts first rises.
    // Returns positioned at the negedge of that first aud_out_rts cycle.
    task automatic run_sample(input logic byp, output int waited, output int wr_seen,
                              output int t_load, output int t_rts, output logic sel_seen);
        mac_t o;
        logic got;
        exp_q.delete();
        obs_q.delete();
        waited   = 0;
        wr_seen  = -1;
        t_load   = -1;
        t_rts    = -1;
        sel_seen = 1'b0;
        got      = 1'b0;
        rf_filter_en = 1'b1;
        aud_in_rts   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (aud_in_rtr && hist_wr_en) begin
                got = 1'b1;
                break;
            end
            waited++;
            @(posedge clk); #1;
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: no handshake within 40 cycles");
            aud_in_rts = 1'b0;
            return;
        end
        wr_seen = int'(hist_wr_ptr);
        if (!byp) push_expected(m_wptr);
        m_wptr = (m_wptr + 1) % NT;
        @(posedge clk); #1;
        aud_in_rts  = 1'b0;
        rf_hist_clr = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            if (mac_en) begin
                o.rd   = hist_rd_ptr;
                o.coef = coef_idx;
                o.clr  = mac_clr;
                o.last = mac_last;
                obs_q.push_back(o);
            end
            if (out_load && t_load < 0) begin
                t_load = t;
`ifdef FILT_SEQ_CTRL_BYPASS_EN
                sel_seen = out_sel;
`endif
            end
            if (aud_out_rts) begin
                t_rts = t;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rf_filter_en = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if ({aud_out_rts, mac_en, out_load, aud_in_rtr} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: rts/mac_en/load/rtr=%b want 0000",
                     {aud_out_rts, mac_en, out_load, aud_in_rtr});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < NT; i++) begin
            @(negedge clk);
            n_tests++;
            if ({hist_wr_en, hist_wr_zero, aud_in_rtr} !== 3'b110 || int'(hist_wr_ptr) != i) begin
                n_fail++;
                $display("FAIL reset_sweep[%0d]: en/zero/rtr=%b ptr=%0d want 110 ptr=%0d",
                         i, {hist_wr_en, hist_wr_zero, aud_in_rtr}, hist_wr_ptr, i);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_tests++;
        if ({aud_in_rtr, hist_wr_en} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_idle: rtr/wr_en=%b want 10", {aud_in_rtr, hist_wr_en});
        end
        @(posedge clk); #1;
        m_wptr = 0;
    endtask

    task automatic test_single();
        int w, wr, tl, tr, exp_wr;
        logic s;
        mac_t e, o;
        aud_out_rtr = 1'b1;
        exp_wr = m_wptr;
        run_sample(1'b0, w, wr, tl, tr, s);
        n_tests++;
        if (wr != exp_wr || tl != NT + ML + 1 || tr != NT + ML + 2) begin
            n_fail++;
            $display("FAIL single_timing: wr=%0d load@%0d rts@%0d want wr=%0d load@%0d rts@%0d",
                     wr, tl, tr, exp_wr, NT + ML + 1, NT + ML + 2);
        end
        for (int k = 0; k < NT; k++) begin
            n_tests++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL single_mac[%0d]: obs entries %0d, exp entries %0d",
                         k, obs_q.size(), exp_q.size());
            end else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL single_mac[%0d]: rd=%0d coef=%0d clr=%b last=%b want rd=%0d coef=%0d clr=%b last=%b",
                             k, o.rd, o.coef, o.clr, o.last, e.rd, e.coef, e.clr, e.last);
                end
            end
        end
        n_tests++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL single_extra_mac: %0d extra mac_en cycles, want 0", obs_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_hist_clr();
        int w, wr, tl, tr;
        logic s;
        aud_out_rtr = 1'b1;
        rf_hist_clr = 1'b1;
        run_sample(1'b0, w, wr, tl, tr, s);
        n_tests++;
        if (w != 0 || tl != NT + ML + 1 || tr != NT + ML + 2) begin
            n_fail++;
            $display("FAIL clr_with_accept: waited=%0d load@%0d rts@%0d want 0/%0d/%0d",
                     w, tl, tr, NT + ML + 1, NT + ML + 2);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if ({aud_in_rtr, hist_wr_en} !== 2'b10) begin
            n_fail++;
            $display("FAIL clr_dropped: rtr/wr_en=%b want 10 (no sweep)", {aud_in_rtr, hist_wr_en});
        end
        @(posedge clk); #1;
        rf_hist_clr = 1'b1;
        @(negedge clk);
        n_tests++;
        if (hist_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_pulse_cycle: wr_en=%b want 0", hist_wr_en);
        end
        @(posedge clk); #1;
        rf_hist_clr = 1'b0;
        for (int i = 0; i < NT; i++) begin
            @(negedge clk);
            n_tests++;
            if ({hist_wr_en, hist_wr_zero, aud_in_rtr} !== 3'b110 || int'(hist_wr_ptr) != i) begin
                n_fail++;
                $display("FAIL clr_sweep[%0d]: en/zero/rtr=%b ptr=%0d want 110 ptr=%0d",
                         i, {hist_wr_en, hist_wr_zero, aud_in_rtr}, hist_wr_ptr, i);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_tests++;
        if (aud_in_rtr !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_idle: rtr=%b want 1", aud_in_rtr);
        end
        @(posedge clk); #1;
        m_wptr = 0;
    endtask

    task automatic test_back_to_back();
        int w, wr, tl, tr, exp_wr;
        logic s;
        mac_t e, o;
        aud_out_rtr = 1'b1;
        for (int smp = 0; smp < 5; smp++) begin
            exp_wr = m_wptr;
            run_sample(1'b0, w, wr, tl, tr, s);
            n_tests++;
            if (w != 0 || wr != exp_wr || tl != NT + ML + 1 || tr != NT + ML + 2) begin
                n_fail++;
                $display("FAIL b2b[%0d]: waited=%0d wr=%0d load@%0d rts@%0d want 0/%0d/%0d/%0d",
                         smp, w, wr, tl, tr, exp_wr, NT + ML + 1, NT + ML + 2);
            end
            for (int k = 0; k < NT; k++) begin
                n_tests++;
                if (exp_q.size() == 0 || obs_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_mac[%0d][%0d]: obs entries %0d, exp entries %0d",
                             smp, k, obs_q.size(), exp_q.size());
                end else begin
                    e = exp_q.pop_front();
                    o = obs_q.pop_front();
                    if (o !== e) begin
                        n_fail++;
                        $display("FAIL b2b_mac[%0d][%0d]: rd=%0d coef=%0d clr=%b last=%b want rd=%0d coef=%0d clr=%b last=%b",
                                 smp, k, o.rd, o.coef, o.clr, o.last, e.rd, e.coef, e.clr, e.last);
                    end
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_filter_en();
        rf_filter_en = 1'b0;
        aud_in_rts   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if ({aud_in_rtr, hist_wr_en} !== 2'b00) begin
                n_fail++;
                $display("FAIL filter_en_off[%0d]: rtr/wr_en=%b want 00", i, {aud_in_rtr, hist_wr_en});
            end
            @(posedge clk); #1;
        end
        aud_in_rts   = 1'b0;
        rf_filter_en = 1'b1;
    endtask

    task automatic test_stall();
        int w, wr, tl, tr;
        logic s, seen;
        aud_out_rtr = 1'b0;
        run_sample(1'b0, w, wr, tl, tr, s);
        aud_in_rts = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
                @(negedge clk);
            end
            n_tests++;
            if ({aud_out_rts, aud_in_rtr, hist_wr_en} !== 3'b100) begin
                n_fail++;
                $display("FAIL stall[%0d]: rts/rtr/wr_en=%b want 100", i, {aud_out_rts, aud_in_rtr, hist_wr_en});
            end
        end
        @(posedge clk); #1;
        aud_out_rtr = 1'b1;
        @(negedge clk);
        n_tests++;
        if (aud_out_rts !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: rts=%b want 1", aud_out_rts);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if ({aud_in_rtr, hist_wr_en, aud_out_rts} !== 3'b110) begin
            n_fail++;
            $display("FAIL stall_idle: rtr/wr_en/rts=%b want 110", {aud_in_rtr, hist_wr_en, aud_out_rts});
        end
        m_wptr = (m_wptr + 1) % NT;
        @(posedge clk); #1;
        aud_in_rts = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (aud_out_rts) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL stall_drain: rts=0 after 30 cycles want 1");
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rst_mid_mac();
        int newest;
        logic got;
        got = 1'b0;
        newest = m_wptr;
        rf_filter_en = 1'b1;
        aud_in_rts   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (aud_in_rtr && hist_wr_en) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        aud_in_rts = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if (!got || mac_en !== 1'b1 || int'(coef_idx) != 2 || int'(hist_rd_ptr) != (newest - 2 + NT) % NT) begin
            n_fail++;
            $display("FAIL rst_tap2: accepted=%b mac_en=%b coef=%0d rd=%0d want 1/1/2/%0d",
                     got, mac_en, coef_idx, hist_rd_ptr, (newest - 2 + NT) % NT);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({mac_en, mac_clr, mac_last, out_load, aud_out_rts, aud_in_rtr} !== 6'b000000) begin
            n_fail++;
            $display("FAIL rst_strobes: en/clr/last/load/rts/rtr=%b want 000000",
                     {mac_en, mac_clr, mac_last, out_load, aud_out_rts, aud_in_rtr});
        end
        for (int i = 0; i < NT; i++) begin
            if (i > 0) @(negedge clk);
            n_tests++;
            if ({hist_wr_en, hist_wr_zero} !== 2'b11 || int'(hist_wr_ptr) != i) begin
                n_fail++;
                $display("FAIL rst_sweep[%0d]: en/zero=%b ptr=%0d want 11 ptr=%0d",
                         i, {hist_wr_en, hist_wr_zero}, hist_wr_ptr, i);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_tests++;
        if (aud_in_rtr !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_idle: rtr=%b want 1", aud_in_rtr);
        end
        @(posedge clk); #1;
        m_wptr = 0;
    endtask

`ifdef FILT_SEQ_CTRL_BYPASS_EN
    task automatic test_bypass();
        int w, wr, tl, tr, exp_wr;
        logic s;
        aud_out_rtr = 1'b1;
        rf_filter_bypass = 1'b1;
        exp_wr = m_wptr;
        run_sample(1'b1, w, wr, tl, tr, s);
        n_tests++;
        if (wr != exp_wr || tl != 1 || tr != 2 || s !== 1'b1 || obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL bypass: wr=%0d load@%0d rts@%0d sel=%b macs=%0d want %0d/1/2/1/0",
                     wr, tl, tr, s, obs_q.size(), exp_wr);
        end
        @(posedge clk); #1;
        rf_filter_bypass = 1'b0;
        run_sample(1'b0, w, wr, tl, tr, s);
        n_tests++;
        if (tl != NT + ML + 1 || s !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_off: load@%0d sel=%b want %0d/0", tl, s, NT + ML + 1);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        m_wptr       = 0;
        rst          = 1'b1;
        rf_filter_en = 1'b0;
        rf_hist_clr  = 1'b0;
        aud_in_rts   = 1'b0;
        aud_out_rtr  = 1'b0;
`ifdef FILT_SEQ_CTRL_BYPASS_EN
        rf_filter_bypass = 1'b0;
`endif
        test_reset();
        test_single();
        test_hist_clr();
        test_back_to_back();
        test_filter_en();
        test_stall();
        test_rst_mid_mac();
`ifdef FILT_SEQ_CTRL_BYPASS_EN
        test_bypass();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
